reg_access_ctrl: RTL and testbench

Register-file access controller for the Neptune I general purpose register array. It sits between the pipeline (two read requesters, one writeback requester) and the dual port register array. Each cycle it time-multiplexes the array's shared read/write address ports, buffers writebacks in a small queue, and never issues same-address dual writes. Read data includes bypass of still-queued writes.

---
 rtl/neptune_reg_pkg.sv | 27 ++
 rtl/reg_wq_fifo.sv | 97 +++++++++
 rtl/reg_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/neptune_reg_pkg.sv
// ============================================================================
// Package  : neptune_reg_pkg
// Purpose  : Shared constants and types for the Neptune I register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package neptune_reg_pkg;

  localparam int REG_WIDTH     = 16;
  localparam int REG_DEPTH     = 8;
  localparam int REG_ADD_WIDTH = 3;

  typedef struct packed {
    logic [REG_ADD_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]     data;
  } wq_entry_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_READ  = 2'd1,
    P_WRITE = 2'd2
  } port_op_t;

endpackage

`default_nettype wire

// File: rtl/reg_wq_fifo.sv
// ============================================================================
// Module   : reg_wq_fifo
// Purpose  : In-order writeback queue with head/head+1 view and youngest-match
//            address lookup for two read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wq_fifo
  import neptune_reg_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter int ADD_WIDTH = REG_ADD_WIDTH,
  parameter int QDEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [ADD_WIDTH-1:0]      i_push_addr,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic [1:0]                i_pop_cnt,
  output logic [$clog2(QDEPTH):0]   o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [ADD_WIDTH-1:0]      o_head_addr,
  output logic [WIDTH-1:0]          o_head_data,
  output logic [ADD_WIDTH-1:0]      o_next_addr,
  output logic [WIDTH-1:0]          o_next_data,
  input  logic [ADD_WIDTH-1:0]      i_look_addr1,
  input  logic [ADD_WIDTH-1:0]      i_look_addr2,
  output logic                      o_hit1,
  output logic [WIDTH-1:0]          o_hit_data1,
  output logic                      o_hit2,
  output logic [WIDTH-1:0]          o_hit_data2
);

  localparam int c_PW = $clog2(QDEPTH);

  logic [ADD_WIDTH-1:0] r_addr [QDEPTH];
  logic [WIDTH-1:0]     r_data [QDEPTH];
  logic [c_PW-1:0]      r_head;
  logic [c_PW-1:0]      r_tail;
  logic [c_PW:0]        r_count;
  logic [c_PW-1:0]      w_idx;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_PW'(i_pop_cnt);
      r_tail  <= r_tail + c_PW'(i_push);
      r_count <= r_count + (c_PW+1)'(i_push) - (c_PW+1)'(i_pop_cnt);
    end
  end

  assign o_count     = r_count;
  assign o_full      = (r_count == (c_PW+1)'(QDEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_next_addr = r_addr[r_head + c_PW'(1)];
  assign o_next_data = r_data[r_head + c_PW'(1)];

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    o_hit1      = 1'b0;
    o_hit_data1 = '0;
    o_hit2      = 1'b0;
    o_hit_data2 = '0;
    w_idx       = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      w_idx = r_head + c_PW'(i);
      if ((c_PW+1)'(i) < r_count) begin
        if (r_addr[w_idx] == i_look_addr1) begin
          o_hit1      = 1'b1;
          o_hit_data1 = r_data[w_idx];
        end
        if (r_addr[w_idx] == i_look_addr2) begin
          o_hit2      = 1'b1;
          o_hit_data2 = r_data[w_idx];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_access_ctrl.sv
// ============================================================================
// Module   : reg_access_ctrl
// Purpose  : Time-multiplexes two reads and queued writebacks onto the dual
//            port register array, with bypass of still-queued writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_access_ctrl
  import neptune_reg_pkg::*;
#(
  parameter int WIDTH      = REG_WIDTH,
  parameter int DEPTH      = REG_DEPTH,
  parameter int ADD_WIDTH  = $clog2(DEPTH),
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rv1,
  input  logic [ADD_WIDTH-1:0] ra1,
  input  logic                 rv2,
  input  logic [ADD_WIDTH-1:0] ra2,
  output logic                 rrdy2,
  output logic                 rvalid1,
  output logic                 rvalid2,
  output logic [WIDTH-1:0]     rdata1,
  output logic [WIDTH-1:0]     rdata2,
  input  logic                 wv,
  input  logic [ADD_WIDTH-1:0] wa,
  input  logic [WIDTH-1:0]     wd,
  output logic                 wrdy,
  output logic                 wq_empty,
  output logic                 we1,
  output logic                 we2,
  output logic [ADD_WIDTH-1:0] add1,
  output logic [ADD_WIDTH-1:0] add2,
  output logic [WIDTH-1:0]     wr1,
  output logic [WIDTH-1:0]     wr2,
  input  logic [WIDTH-1:0]     rd1,
  input  logic [WIDTH-1:0]     rd2
);

  localparam int c_CW = $clog2(QDEPTH) + 1;
  localparam int c_SW = $clog2(STARVE_MAX + 1);

  logic [c_CW-1:0]      w_count;
  logic                 w_full, w_empty, w_push;
  logic [ADD_WIDTH-1:0] w_head_addr, w_next_addr;
  logic [WIDTH-1:0]     w_head_data, w_next_data;
  logic                 w_hit1, w_hit2;
  logic [WIDTH-1:0]     w_hit_data1, w_hit_data2;
  port_op_t             w_op1, w_op2;
  logic                 w_head_on_p1, w_forced, w_p2_next;
  logic                 w_head_iss, w_next_iss;
  logic [1:0]           w_pop_cnt;
  logic [c_SW-1:0]      r_starve, w_starve_nxt;
  logic                 r_rvalid1, r_rvalid2, r_byp1, r_byp2;
  logic [WIDTH-1:0]     r_bdata1, r_bdata2;

  assign w_push = wv && !w_full;

  reg_wq_fifo #(
    .WIDTH     (WIDTH),
    .ADD_WIDTH (ADD_WIDTH),
    .QDEPTH    (QDEPTH)
  ) u_wq (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (wa),
    .i_push_data  (wd),
    .i_pop_cnt    (w_pop_cnt),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_next_addr  (w_next_addr),
    .o_next_data  (w_next_data),
    .i_look_addr1 (ra1),
    .i_look_addr2 (ra2),
    .o_hit1       (w_hit1),
    .o_hit_data1  (w_hit_data1),
    .o_hit2       (w_hit2),
    .o_hit_data2  (w_hit_data2)
  );

  // head+1 may only follow the head in the same cycle and never to its address.
  always_comb begin
    w_op1        = P_IDLE;
    w_op2        = P_IDLE;
    w_p2_next    = 1'b0;
    w_next_iss   = 1'b0;
    rrdy2        = 1'b1;
    w_head_on_p1 = !rv1 && !w_empty;
    w_forced     = (r_starve == c_SW'(STARVE_MAX)) && !w_head_on_p1 && !w_empty;
    w_head_iss   = w_head_on_p1;
    if (rv1)               w_op1 = P_READ;
    else if (!w_empty)     w_op1 = P_WRITE;
    if (w_forced) begin
      w_op2      = P_WRITE;
      rrdy2      = 1'b0;
      w_head_iss = 1'b1;
    end else if (rv2) begin
      w_op2 = P_READ;
    end else if (w_head_on_p1) begin
      if (w_count >= c_CW'(2) && w_next_addr != w_head_addr) begin
        w_op2      = P_WRITE;
        w_p2_next  = 1'b1;
        w_next_iss = 1'b1;
      end
    end else if (!w_empty) begin
      w_op2      = P_WRITE;
      w_head_iss = 1'b1;
    end
    w_pop_cnt = {1'b0, w_head_iss} + {1'b0, w_next_iss};
  end

  always_comb begin
    we1  = 1'b0;
    add1 = '0;
    wr1  = '0;
    we2  = 1'b0;
    add2 = '0;
    wr2  = '0;
    case (w_op1)
      P_READ:  add1 = ra1;
      P_WRITE: begin we1 = 1'b1; add1 = w_head_addr; wr1 = w_head_data; end
      default: ;
    endcase
    case (w_op2)
      P_READ:  add2 = ra2;
      P_WRITE: begin
        we2  = 1'b1;
        add2 = w_p2_next ? w_next_addr : w_head_addr;
        wr2  = w_p2_next ? w_next_data : w_head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_head_iss)                  w_starve_nxt = '0;
    else if (r_starve != c_SW'(STARVE_MAX))     w_starve_nxt = r_starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve  <= '0;
      r_rvalid1 <= 1'b0;
      r_rvalid2 <= 1'b0;
      r_byp1    <= 1'b0;
      r_byp2    <= 1'b0;
      r_bdata1  <= '0;
      r_bdata2  <= '0;
    end else begin
      r_starve  <= w_starve_nxt;
      r_rvalid1 <= rv1;
      r_rvalid2 <= rv2 && rrdy2;
      r_byp1    <= rv1 && w_hit1;
      r_byp2    <= rv2 && rrdy2 && w_hit2;
      r_bdata1  <= w_hit_data1;
      r_bdata2  <= w_hit_data2;
    end
  end

  assign rvalid1  = r_rvalid1;
  assign rvalid2  = r_rvalid2;
  assign rdata1   = r_rvalid1 ? (r_byp1 ? r_bdata1 : rd1) : '0;
  assign rdata2   = r_rvalid2 ? (r_byp2 ? r_bdata2 : rd2) : '0;
  assign wrdy     = !w_full;
  assign wq_empty = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_reg_access_ctrl.sv
// ============================================================================
// Module   : tb_reg_access_ctrl
// Purpose  : Directed vector bench for reg_access_ctrl with an array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_access_ctrl;

  typedef struct packed {
    logic        rrdy2, wrdy, wq_empty;
    logic        we1;
    logic [2:0]  add1;
    logic [15:0] wr1;
    logic        we2;
    logic [2:0]  add2;
    logic [15:0] wr2;
    logic        rvalid1;
    logic [15:0] rdata1;
    logic        rvalid2;
    logic [15:0] rdata2;
  } outs_t;

  typedef struct {
    int    rv1, ra1, rv2, ra2, wv, wa, wd;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv1 = 1'b0, rv2 = 1'b0, wv = 1'b0;
  logic [2:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [15:0] wd = '0;
  logic        rrdy2, rvalid1, rvalid2, wrdy, wq_empty, we1, we2;
  logic [15:0] rdata1, rdata2, wr1, wr2, rd1, rd2;
  logic [2:0]  add1, add2;
  logic [15:0] arr [8];

  int checks = 0, failures = 0;
  int pulses = 0, same_addr = 0, addr7_writes = 0, mark = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .clk(clk), .rst(rst),
    .rv1(rv1), .ra1(ra1), .rv2(rv2), .ra2(ra2), .rrdy2(rrdy2),
    .rvalid1(rvalid1), .rvalid2(rvalid2), .rdata1(rdata1), .rdata2(rdata2),
    .wv(wv), .wa(wa), .wd(wd), .wrdy(wrdy), .wq_empty(wq_empty),
    .we1(we1), .we2(we2), .add1(add1), .add2(add2), .wr1(wr1), .wr2(wr2),
    .rd1(rd1), .rd2(rd2)
  );

  // Register array: registered read of the old contents, one cycle latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) arr[i] <= '0;
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      rd1 <= arr[add1];
      rd2 <= arr[add2];
      if (we1) arr[add1] <= wr1;
      if (we2) arr[add2] <= wr2;
    end
  end

  always @(posedge clk) begin
    if (we1) pulses++;
    if (we2) pulses++;
    if (we1 && we2 && add1 == add2) same_addr++;
    if ((we1 && add1 == 3'd7) || (we2 && add2 == 3'd7)) addr7_writes++;
  end

  function automatic outs_t mk(input int rr2, input int wr, input int emp,
                               input int e1, input int a1, input int w1,
                               input int e2, input int a2, input int w2,
                               input int v1, input int d1, input int v2, input int d2);
    outs_t o;
    o.rrdy2 = rr2[0]; o.wrdy = wr[0]; o.wq_empty = emp[0];
    o.we1 = e1[0]; o.add1 = a1[2:0]; o.wr1 = w1[15:0];
    o.we2 = e2[0]; o.add2 = a2[2:0]; o.wr2 = w2[15:0];
    o.rvalid1 = v1[0]; o.rdata1 = d1[15:0];
    o.rvalid2 = v2[0]; o.rdata2 = d2[15:0];
    return o;
  endfunction

  function automatic void v(input int i_rv1, input int i_ra1, input int i_rv2, input int i_ra2,
                            input int i_wv, input int i_wa, input int i_wd, input outs_t e);
    vec_t x;
    x.rv1 = i_rv1; x.ra1 = i_ra1; x.rv2 = i_rv2; x.ra2 = i_ra2;
    x.wv = i_wv; x.wa = i_wa; x.wd = i_wd; x.exp = e;
    vecs.push_back(x);
  endfunction

  function automatic outs_t sample();
    return {rrdy2, wrdy, wq_empty, we1, add1, wr1, we2, add2, wr2,
            rvalid1, rdata1, rvalid2, rdata2};
  endfunction

  task automatic drive(input int i_rv1, input int i_ra1, input int i_rv2, input int i_ra2,
                       input int i_wv, input int i_wa, input int i_wd);
    @(negedge clk);
    rv1 = i_rv1[0]; ra1 = i_ra1[2:0]; rv2 = i_rv2[0]; ra2 = i_ra2[2:0];
    wv = i_wv[0]; wa = i_wa[2:0]; wd = i_wd[15:0];
    #1;
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //  rv1 ra1 rv2 ra2 wv wa wd             rr2 wrdy emp we1 a1 wr1    we2 a2 wr2    rv1 d1     rv2 d2
    v(0,0,0,0, 0,0,0,           mk(1,1,1, 0,0,0,       0,0,0,       0,0,       0,0));
    v(0,0,0,0, 1,3,'hBEEF,      mk(1,1,1, 0,0,0,       0,0,0,       0,0,       0,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,0, 1,3,'hBEEF,  0,0,0,       0,0,       0,0));
    v(1,3,0,0, 0,0,0,           mk(1,1,1, 0,3,0,       0,0,0,       0,0,       0,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,1, 0,0,0,       0,0,0,       1,'hBEEF,  0,0));
    v(1,0,1,0, 1,5,'h1111,      mk(1,1,1, 0,0,0,       0,0,0,       0,0,       0,0));
    v(1,0,1,0, 1,5,'h2222,      mk(1,1,0, 0,0,0,       0,0,0,       1,0,       1,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,0, 1,5,'h1111,  0,0,0,       1,0,       1,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,0, 1,5,'h2222,  0,0,0,       0,0,       0,0));
    v(0,0,1,5, 0,0,0,           mk(1,1,1, 0,0,0,       0,5,0,       0,0,       0,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,1, 0,0,0,       0,0,0,       0,0,       1,'h2222));
    v(0,0,0,0, 1,2,'hAAAA,      mk(1,1,1, 0,0,0,       0,0,0,       0,0,       0,0));
    v(1,2,0,0, 0,0,0,           mk(1,1,0, 0,2,0,       1,2,'hAAAA,  0,0,       0,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,1, 0,0,0,       0,0,0,       1,'hAAAA,  0,0));
    v(1,7,1,7, 1,1,'h0101,      mk(1,1,1, 0,7,0,       0,7,0,       0,0,       0,0));
    v(1,7,1,7, 1,4,'h0404,      mk(1,1,0, 0,7,0,       0,7,0,       1,0,       1,0));
    v(1,1,1,4, 0,0,0,           mk(1,1,0, 0,1,0,       0,4,0,       1,0,       1,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,0, 1,1,'h0101,  1,4,'h0404,  1,'h0101,  1,'h0404));
    v(1,4,1,1, 0,0,0,           mk(1,1,1, 0,4,0,       0,1,0,       0,0,       0,0));
    v(0,0,0,0, 0,0,0,           mk(1,1,1, 0,0,0,       0,0,0,       1,'h0404,  1,'h0101));

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rv1, vecs[i].ra1, vecs[i].rv2, vecs[i].ra2,
            vecs[i].wv, vecs[i].wa, vecs[i].wd);
      check_outs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Starvation: both ports keep reading while one write waits.
    drive(1,0,1,0, 1,6,'h6666);
    for (int i = 1; i <= 3; i++) begin
      drive(1,0,1,0, 0,0,0);
      check_val($sformatf("starve_wait%0d", i), {30'd0, rrdy2, we2}, 2);
    end
    drive(1,0,1,0, 0,0,0);
    check_outs("starve_forced", mk(0,1,0, 0,0,0, 1,6,'h6666, 1,0, 1,0));
    drive(1,0,1,0, 0,0,0);
    check_outs("starve_after", mk(1,1,1, 0,0,0, 0,0,0, 1,0, 0,0));

    // Fill to capacity while reads block the ports.
    for (int i = 1; i <= 4; i++) begin
      drive(1,0,1,0, 1,i,'hF000 + i);
      check_val($sformatf("fill_wrdy%0d", i), {31'd0, wrdy}, 1);
    end
    drive(1,0,1,0, 1,7,'hDEAD);
    mark = pulses;
    check_val("full_wrdy", {31'd0, wrdy}, 0);
    check_val("full_forced", {we2, add2, wr2, rrdy2}, {1'b1, 3'd1, 16'hF001, 1'b0});
    drive(0,0,0,0, 0,0,0);
    check_val("drain_dual", {we1, add1, wr1, we2, add2, wr2},
              {1'b1, 3'd2, 16'hF002, 1'b1, 3'd3, 16'hF003});
    repeat (3) drive(0,0,0,0, 0,0,0);
    check_val("full_drain_writes", pulses - mark, 4);
    check_val("rejected_push", addr7_writes, 0);

    // Reset mid-operation with queued writes and reads in flight.
    drive(1,0,1,0, 1,1,'h0001);
    drive(1,0,1,0, 1,2,'h0002);
    drive(1,0,1,0, 1,3,'h0003);
    @(negedge clk);
    rst = 1'b1; wv = 1'b0;
    @(negedge clk);
    rst = 1'b0; rv1 = 1'b0; rv2 = 1'b0;
    #1;
    check_val("rst_state", {rvalid1, rvalid2, wq_empty, wrdy}, 4'b0011);
    check_val("rst_rdata", {rdata1, rdata2}, 0);
    mark = pulses;
    repeat (4) drive(0,0,0,0, 0,0,0);
    check_val("rst_no_writes", pulses - mark, 0);
    check_val("no_same_addr_dual", same_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
